// File: rtl/alu_flags_wb_if.sv
// ALU-to-write-back handshake bundle: the ALU result input side and the
// register-file write-back output side of the flags/write-back stage.
interface alu_flags_wb_if #(
   parameter int DATA_W = 8,
   parameter int DEST_W = 2
);
   logic [DATA_W-1:0] aluout;
   logic              carryout;
   logic              overout;
   logic              cmpo;
   logic [DEST_W-1:0] alu_dest;
   logic              alu_valid;
   logic              alu_ready;
   logic              wb_valid;
   logic              wb_ready;
   logic [DATA_W-1:0] wb_data;
   logic [DEST_W-1:0] wb_dest;

   modport slave (
      input  aluout, carryout, overout, cmpo, alu_dest, alu_valid, wb_ready,
      output alu_ready, wb_valid, wb_data, wb_dest
   );

   modport master (
      output aluout, carryout, overout, cmpo, alu_dest, alu_valid, wb_ready,
      input  alu_ready, wb_valid, wb_data, wb_dest
   );
endinterface

// File: rtl/alu_flags_wb.sv
// Post-ALU stage: captures results into a one-entry write-back buffer and keeps Z/N/C/O flags.
// Latency: flags and buffered result visible 1 cycle after accept; cond_true is combinational.
// Backpressure: alu_ready = ~wb_valid | wb_ready, so a draining buffer refills without a bubble.
module alu_flags_wb #(
   parameter int DATA_W = 8,
   parameter int DEST_W = 2
) (
   input  logic                clk,
   input  logic                rst,
   alu_flags_wb_if.slave       bus,
   output logic                carry_to_alu,
   output logic [3:0]          flags,
   input  logic                flags_load,
   input  logic [3:0]          flags_in,
   input  logic [3:0]          cond,
   output logic                cond_true
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] data_q;
   logic [DEST_W-1:0] dest_q;
   logic [3:0]        flags_q;
   logic              accept;
   logic              load;

   logic z_f, n_f, c_f, o_f;

   assign bus.alu_ready = (state_q == EMPTY) | bus.wb_ready;
   assign accept        = bus.alu_valid & bus.alu_ready;
   // Compare-only ops touch flags but never occupy the buffer.
   assign load          = accept & ~bus.cmpo;

   assign bus.wb_valid  = (state_q == FULL);
   assign bus.wb_data   = data_q;
   assign bus.wb_dest   = dest_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (load) state_d = FULL;
         FULL:  if (bus.wb_ready && !load) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         data_q  <= '0;
         dest_q  <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            data_q <= bus.aluout;
            dest_q <= bus.alu_dest;
         end
      end
   end

   // Flag order is {O,C,N,Z}; an explicit restore beats a same-cycle result.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
      end else if (flags_load) begin
         flags_q <= flags_in;
      end else if (accept) begin
         flags_q <= {bus.overout, bus.carryout, bus.aluout[DATA_W-1], (bus.aluout == '0)};
      end
   end

   assign flags        = flags_q;
   assign carry_to_alu = flags_q[2];

   assign z_f = flags_q[0];
   assign n_f = flags_q[1];
   assign c_f = flags_q[2];
   assign o_f = flags_q[3];

   always_comb begin
      cond_true = 1'b0;
      case (cond)
         4'd0:  cond_true = 1'b1;
         4'd1:  cond_true = z_f;
         4'd2:  cond_true = ~z_f;
         4'd3:  cond_true = c_f;
         4'd4:  cond_true = ~c_f;
         4'd5:  cond_true = n_f;
         4'd6:  cond_true = ~n_f;
         4'd7:  cond_true = o_f;
         4'd8:  cond_true = ~o_f;
         4'd9:  cond_true = c_f & ~z_f;
         4'd10: cond_true = n_f ^ o_f;
         4'd11: cond_true = ~(n_f ^ o_f);
         4'd12: cond_true = ~z_f & ~(n_f ^ o_f);
         4'd13: cond_true = z_f | (n_f ^ o_f);
         4'd14: cond_true = ~c_f | z_f;
         default: cond_true = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_alu_flags_wb.sv
// Directed bench for alu_flags_wb: reset, flag capture, backpressure, compare-only,
// flag restore priority, drain/refill and mid-transfer reset.
module tb_alu_flags_wb;

   logic       clk;
   logic       rst;
   logic       carry_to_alu;
   logic [3:0] flags;
   logic       flags_load;
   logic [3:0] flags_in;
   logic [3:0] cond;
   logic       cond_true;

   int checks   = 0;
   int failures = 0;

   alu_flags_wb_if #(.DATA_W(8), .DEST_W(2)) bus ();

   alu_flags_wb #(.DATA_W(8), .DEST_W(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus.slave),
      .carry_to_alu (carry_to_alu),
      .flags        (flags),
      .flags_load   (flags_load),
      .flags_in     (flags_in),
      .cond         (cond),
      .cond_true    (cond_true)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cond(input string tag, input logic [3:0] sel, input logic exp);
      cond = sel;
      #1;
      chk(tag, {31'd0, cond_true}, {31'd0, exp});
   endtask

   initial begin
      rst            = 1'b1;
      bus.aluout     = 8'h00;
      bus.carryout   = 1'b0;
      bus.overout    = 1'b0;
      bus.cmpo       = 1'b0;
      bus.alu_dest   = 2'd0;
      bus.alu_valid  = 1'b0;
      bus.wb_ready   = 1'b0;
      flags_load     = 1'b0;
      flags_in       = 4'b0000;
      cond           = 4'd0;

      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_wb_valid",  {31'd0, bus.wb_valid},  32'd0);
      chk("rst_flags",     {28'd0, flags},         32'd0);
      chk("rst_carry",     {31'd0, carry_to_alu},  32'd0);
      chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
      chk("rst_wb_data",   {24'd0, bus.wb_data},   32'd0);
      chk_cond("rst_cond0",  4'd0,  1'b1);
      chk_cond("rst_cond15", 4'd15, 1'b0);
      tick();
      chk("idle_flags", {28'd0, flags}, 32'd0);

      // Zero result with carry into a stalled register file
      bus.aluout    = 8'h00;
      bus.carryout  = 1'b1;
      bus.overout   = 1'b0;
      bus.alu_dest  = 2'd2;
      bus.alu_valid = 1'b1;
      bus.wb_ready  = 1'b0;
      tick();
      bus.aluout    = 8'h55;
      bus.alu_dest  = 2'd1;
      bus.carryout  = 1'b0;
      #1;
      chk("zc_flags",     {28'd0, flags},         32'h5);
      chk("zc_wb_valid",  {31'd0, bus.wb_valid},  32'd1);
      chk("zc_wb_data",   {24'd0, bus.wb_data},   32'h00);
      chk("zc_wb_dest",   {30'd0, bus.wb_dest},   32'd2);
      chk("zc_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
      chk("zc_carry",     {31'd0, carry_to_alu},  32'd1);
      chk_cond("zc_cond9",  4'd9,  1'b0);
      chk_cond("zc_cond14", 4'd14, 1'b1);

      // Stall: held ALU result must not disturb buffer or flags
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_wb_data",   {24'd0, bus.wb_data},   32'h00);
         chk("stall_flags",     {28'd0, flags},         32'h5);
         chk("stall_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
      end
      bus.wb_ready = 1'b1;
      #1;
      chk("release_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk("refill_wb_data",  {24'd0, bus.wb_data},  32'h55);
      chk("refill_wb_dest",  {30'd0, bus.wb_dest},  32'd1);
      chk("refill_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("refill_flags",    {28'd0, flags},        32'h0);
      tick();
      chk("drain_wb_valid", {31'd0, bus.wb_valid}, 32'd0);

      // Compare-only negative overflow
      bus.cmpo      = 1'b1;
      bus.aluout    = 8'h80;
      bus.overout   = 1'b1;
      bus.carryout  = 1'b0;
      bus.alu_valid = 1'b1;
      tick();
      bus.alu_valid = 1'b0;
      bus.cmpo      = 1'b0;
      #1;
      chk("cmp_flags",    {28'd0, flags},        32'hA);
      chk("cmp_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk_cond("cmp_cond10", 4'd10, 1'b0);
      chk_cond("cmp_cond7",  4'd7,  1'b1);
      chk_cond("cmp_cond12", 4'd12, 1'b1);
      chk_cond("cmp_cond13", 4'd13, 1'b0);

      // Flag restore wins over a simultaneous accept; result still buffered
      bus.wb_ready  = 1'b0;
      flags_load    = 1'b1;
      flags_in      = 4'b0010;
      bus.aluout    = 8'h01;
      bus.carryout  = 1'b0;
      bus.overout   = 1'b1;
      bus.alu_dest  = 2'd3;
      bus.alu_valid = 1'b1;
      tick();
      bus.alu_valid = 1'b0;
      flags_load    = 1'b0;
      #1;
      chk("load_flags",    {28'd0, flags},        32'h2);
      chk("load_wb_data",  {24'd0, bus.wb_data},  32'h01);
      chk("load_wb_dest",  {30'd0, bus.wb_dest},  32'd3);
      chk("load_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk_cond("load_cond6", 4'd6, 1'b0);

      // Draining with a compare-only accept empties the buffer
      bus.wb_ready  = 1'b1;
      bus.cmpo      = 1'b1;
      bus.aluout    = 8'h00;
      bus.carryout  = 1'b1;
      bus.overout   = 1'b0;
      bus.alu_valid = 1'b1;
      tick();
      bus.alu_valid = 1'b0;
      bus.cmpo      = 1'b0;
      #1;
      chk("cmpdrain_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("cmpdrain_flags",    {28'd0, flags},        32'h5);
      chk("cmpdrain_carry",    {31'd0, carry_to_alu}, 32'd1);

      // Chained op sees the carry, then fills the buffer
      bus.wb_ready  = 1'b0;
      bus.aluout    = 8'hFF;
      bus.carryout  = 1'b0;
      bus.overout   = 1'b0;
      bus.alu_dest  = 2'd0;
      bus.alu_valid = 1'b1;
      tick();
      bus.alu_valid = 1'b0;
      #1;
      chk("neg_flags",    {28'd0, flags},        32'h2);
      chk("neg_carry",    {31'd0, carry_to_alu}, 32'd0);
      chk("neg_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
      chk("neg_wb_data",  {24'd0, bus.wb_data},  32'hFF);

      // Reset while the buffer is full
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mrst_wb_valid",  {31'd0, bus.wb_valid},  32'd0);
      chk("mrst_flags",     {28'd0, flags},         32'd0);
      chk("mrst_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
      chk("mrst_carry",     {31'd0, carry_to_alu},  32'd0);
      chk("mrst_wb_data",   {24'd0, bus.wb_data},   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
